instr_buffer: RTL and testbench

//  FIFO that receives IF_IB_PACKETs from the fetch stage and holds them in order.
//  It presents the oldest packet to dispatch using a show-ahead, valid/ready handshake.
//  It raises ib_full to throttle fetch, and it flushes completely on a squash
//  (mispredict/exception recovery).

---
 rtl/instr_buffer.sv | 128 ++++++++++++
 tb/tb_instr_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_buffer.sv
// -----------------------------------------------------------------------------
// instr_buffer
//   In-order instruction buffer between fetch and dispatch.
//   Fetch writes IF_IB_PACKETs at the tail. Dispatch sees the oldest entry at
//   the head through a show-ahead output and pops it with dp_ready.
//   A squash empties the whole buffer for mispredict or exception recovery.
//
// Handshake (valid/ready):
//   Fetch side: a packet is taken on a rising clock edge when
//     if_ib_packet.valid & ~ib_full & ~squash.
//   Fetch must not present a valid packet while ib_full is high. Such a packet
//   is dropped and flagged by an assertion.
//   Dispatch side: the head entry is popped on a rising clock edge when
//     ib_dp_packet.valid & dp_ready.
//   While the head is not popped, ib_dp_packet holds steady.
//
// Ports:
//   clock         in   sole clock, rising edge
//   reset         in   asynchronous, active-low
//   if_ib_packet  in   packet from fetch {inst, PC, NPC, valid}
//   squash        in   flush every entry; any concurrent enqueue is discarded
//   dp_ready      in   dispatch accepts the head entry this cycle
//   ib_full       out  occupancy == IB_DEPTH (registered decode)
//   ib_empty      out  occupancy == 0 (registered decode)
//   ib_dp_packet  out  head entry. When empty, it is an idle packet (NOP, valid=0)
//   ib_count      out  occupancy, $clog2(IB_DEPTH)+1 bits
// -----------------------------------------------------------------------------
package instr_buffer_pkg;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic            valid;
  } IF_IB_PACKET;
endpackage

module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int IB_DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  IF_IB_PACKET               if_ib_packet,
  input  logic                      squash,
  input  logic                      dp_ready,
  output logic                      ib_full,
  output logic                      ib_empty,
  output IF_IB_PACKET               ib_dp_packet,
  output logic [$clog2(IB_DEPTH):0] ib_count
);

  localparam int PTR_W  = $clog2(IB_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // The valid bit is not stored: every stored entry is valid by construction.
  localparam int DATA_W = $bits(IF_IB_PACKET) - 1;

  logic [DATA_W-1:0] mem_q [IB_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              enq, deq;

  // Status flags come only from the registered count. This keeps every
  // combinational path from dp_ready or the fetch valid bit away from
  // fetch's PC-advance logic.
  assign ib_count = count_q;
  assign ib_full  = (count_q == CNT_W'(IB_DEPTH));
  assign ib_empty = (count_q == '0);

  // Show-ahead head. Squash masks valid so that no dequeue happens in the
  // flush cycle.
  always_comb begin
    ib_dp_packet      = '0;
    ib_dp_packet.inst = NOP;
    if (!ib_empty) begin
      ib_dp_packet = {mem_q[head_q], ~squash};
    end
  end

  assign enq = if_ib_packet.valid & ~ib_full & ~squash;
  assign deq = dp_ready & ib_dp_packet.valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because IB_DEPTH is a power of two.
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset because count gates what is visible.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_q[tail_q] <= {if_ib_packet.inst, if_ib_packet.PC, if_ib_packet.NPC};
    end
  end

  // Fetch protocol check. A valid packet while full is dropped and state is
  // left unchanged.
  assert property (@(posedge clock) disable iff (!reset)
                   !(if_ib_packet.valid && ib_full))
    else $warning("instr_buffer: fetch presented a valid packet while ib_full; packet dropped");

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock;
  logic        reset;
  IF_IB_PACKET if_ib_packet;
  logic        squash;
  logic        dp_ready;
  logic        ib_full;
  logic        ib_empty;
  IF_IB_PACKET ib_dp_packet;
  logic [3:0]  ib_count;

  int n_checks = 0;
  int n_err    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  instr_buffer #(.IB_DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_ib_packet (if_ib_packet),
    .squash       (squash),
    .dp_ready     (dp_ready),
    .ib_full      (ib_full),
    .ib_empty     (ib_empty),
    .ib_dp_packet (ib_dp_packet),
    .ib_count     (ib_count)
  );

  // ---------------- helpers ----------------
  function automatic IF_IB_PACKET mk(input logic [31:0] pc);
    IF_IB_PACKET p;
    p.inst  = 32'hA500_0000 ^ {pc[15:0], 16'h0013};
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  function automatic IF_IB_PACKET idle_pkt();
    IF_IB_PACKET p;
    p      = '0;
    p.inst = 32'h0000_0013;
    return p;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input IF_IB_PACKET p, input logic rdy, input logic sq);
    if_ib_packet = p;
    dp_ready     = rdy;
    squash       = sq;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive('0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    // Reset state
    chk("rst_full",  ib_full,  0);
    chk("rst_empty", ib_empty, 1);
    chk("rst_count", ib_count, 0);
    chk("rst_pkt",   ib_dp_packet, idle_pkt());
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // 1. Fill with 8 packets, dp_ready=0
    for (int i = 0; i < 8; i++) begin
      drive(mk(32'(i * 4)), 1'b0, 1'b0);
      #1;
      if (i == 0) begin
        chk("t1_no_bypass_empty", ib_empty, 1);
        chk("t1_no_bypass_valid", ib_dp_packet.valid, 0);
      end else begin
        chk("t1_count", ib_count, 4'(i));
        chk("t1_head",  ib_dp_packet, mk(32'h0));
      end
      tick();
    end
    drive('0, 1'b0, 1'b0);
    #1;
    chk("t1_full",  ib_full, 1);
    chk("t1_count8", ib_count, 8);
    chk("t1_head0", ib_dp_packet, mk(32'h0));

    // 2. Valid packet while full is dropped
    drive(mk(32'h20), 1'b0, 1'b0);
    tick();
    drive('0, 1'b0, 1'b0);
    #1;
    chk("t2_count", ib_count, 8);
    chk("t2_full",  ib_full, 1);
    chk("t2_head",  ib_dp_packet, mk(32'h0));

    // 3. Full, dp_ready=1 with valid in: dequeue only
    drive(mk(32'h20), 1'b1, 1'b0);
    #1;
    chk("t3_full_no_comb", ib_full, 1);
    tick();
    chk("t3_count7", ib_count, 7);
    chk("t3_full_drop", ib_full, 0);
    drive(mk(32'h20), 1'b0, 1'b0);
    tick();
    drive('0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_drain", ib_dp_packet, mk(32'(4 + 4 * i)));
      tick();
    end
    chk("t3_empty", ib_empty, 1);
    chk("t3_count0", ib_count, 0);

    // 4. Streaming 20 packets with dp_ready held high
    for (int k = 0; k < 20; k++) begin
      drive(mk(32'(4 * k)), 1'b1, 1'b0);
      #1;
      if (k == 0) begin
        chk("t4_first_empty", ib_empty, 1);
      end else begin
        chk("t4_stream", ib_dp_packet, mk(32'(4 * (k - 1))));
        chk("t4_count",  ib_count, 1);
      end
      tick();
    end
    drive('0, 1'b1, 1'b0);
    #1;
    chk("t4_last", ib_dp_packet, mk(32'h4C));
    tick();
    chk("t4_empty", ib_empty, 1);

    // 5. Squash with 5 entries and a concurrent valid packet
    for (int i = 0; i < 5; i++) begin
      drive(mk(32'(32'h200 + 4 * i)), 1'b0, 1'b0);
      tick();
    end
    drive(mk(32'h100), 1'b1, 1'b1);
    #1;
    chk("t5_sq_valid", ib_dp_packet.valid, 0);
    chk("t5_sq_count", ib_count, 5);
    tick();
    drive('0, 1'b0, 1'b0);
    #1;
    chk("t5_empty", ib_empty, 1);
    chk("t5_count", ib_count, 0);
    chk("t5_idle",  ib_dp_packet, idle_pkt());
    drive(mk(32'h300), 1'b0, 1'b0);
    tick();
    drive('0, 1'b0, 1'b0);
    #1;
    chk("t5_after_head",  ib_dp_packet, mk(32'h300));
    chk("t5_after_count", ib_count, 1);
    drive('0, 1'b1, 1'b0);
    tick();
    drive('0, 1'b0, 1'b0);

    // 6. Asynchronous reset in mid-cycle with 3 entries
    for (int i = 0; i < 3; i++) begin
      drive(mk(32'(32'h500 + 4 * i)), 1'b0, 1'b0);
      tick();
    end
    drive('0, 1'b0, 1'b0);
    #1;
    chk("t6_pre_count", ib_count, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_count", ib_count, 0);
    chk("t6_async_empty", ib_empty, 1);
    chk("t6_async_full",  ib_full, 0);
    chk("t6_async_pkt",   ib_dp_packet, idle_pkt());
    #2;
    reset = 1'b1;
    tick();
    drive(mk(32'h40), 1'b0, 1'b0);
    tick();
    drive('0, 1'b0, 1'b0);
    #1;
    chk("t6_head",  ib_dp_packet, mk(32'h40));
    chk("t6_count", ib_count, 1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
